// File: rtl/tnoc_pkg.sv
// Shared NoC definitions: output port indices, flit control-bit offsets,
// per-VC input FSM states and the port one-hot helper.
package tnoc_pkg;

  typedef enum logic [2:0] {
    PORT_XP = 3'd0,
    PORT_XM = 3'd1,
    PORT_YP = 3'd2,
    PORT_YM = 3'd3,
    PORT_L  = 3'd4
  } port_e;

  localparam int PORT_COUNT = 5;

  // Control bits are counted down from the flit MSB so they track FLIT_WIDTH.
  localparam int HEAD_OFFSET = 1;
  localparam int TAIL_OFFSET = 2;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_REQUEST = 2'd1,
    VC_ACTIVE  = 2'd2,
    VC_DROP    = 2'd3
  } vc_state_e;

  function automatic logic [PORT_COUNT-1:0] port_onehot(input port_e port);
    return PORT_COUNT'(1) << port;
  endfunction

endpackage

// File: rtl/tnoc_vc_fifo.sv
// Single virtual-channel flit FIFO. The parent only pops when non-empty and
// only pushes when there is room (a same-cycle pop counts as room).
module tnoc_vc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the top entry is only meaningful when non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  assign top   = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/tnoc_vc_input_unit.sv
// Credit-based router input port: per-VC flit FIFOs, XY route on head flits,
// packet-locked output-port request, drop of unroutable packets, credit return.
//
// state      | meaning
// IDLE       | waiting for a head flit at FIFO top; stray body flits discarded
// REQUEST    | route registered, one-hot request held until granted
// ACTIVE     | packet owns the port; forward flits until tail leaves
// DROP       | destination port unavailable; discard flits through tail
module tnoc_vc_input_unit
  import tnoc_pkg::*;
#(
  parameter int         CHANNELS        = 2,
  parameter int         DEPTH           = 4,
  parameter int         FLIT_WIDTH      = 64,
  parameter int         XY_WIDTH        = 4,
  parameter int         X               = 0,
  parameter int         Y               = 0,
  parameter logic [4:0] AVAILABLE_PORTS = 5'b11111,
  localparam int        VC_WIDTH        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic [VC_WIDTH-1:0]            i_vc,
  input  logic [FLIT_WIDTH-1:0]          i_flit,
  output logic [CHANNELS-1:0]            o_credit,
  output logic [CHANNELS*5-1:0]          o_request,
  input  logic [CHANNELS-1:0]            i_grant,
  output logic [CHANNELS-1:0]            o_valid,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic                           o_overflow,
  output logic                           o_route_error
);

  localparam int HEAD_BIT = FLIT_WIDTH - HEAD_OFFSET;
  localparam int TAIL_BIT = FLIT_WIDTH - TAIL_OFFSET;
  localparam logic [XY_WIDTH-1:0] MY_X = XY_WIDTH'(X);
  localparam logic [XY_WIDTH-1:0] MY_Y = XY_WIDTH'(Y);

  logic [CHANNELS-1:0] pop_vec;
  logic [CHANNELS-1:0] overflow_vec;
  logic [CHANNELS-1:0] drop_vec;

  function automatic port_e xy_route(input logic [FLIT_WIDTH-1:0] flit);
    logic [XY_WIDTH-1:0] dest_x;
    logic [XY_WIDTH-1:0] dest_y;
    dest_x = flit[XY_WIDTH-1:0];
    dest_y = flit[2*XY_WIDTH-1:XY_WIDTH];
    if (dest_x > MY_X)      return PORT_XP;
    else if (dest_x < MY_X) return PORT_XM;
    else if (dest_y > MY_Y) return PORT_YP;
    else if (dest_y < MY_Y) return PORT_YM;
    else                    return PORT_L;
  endfunction

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    vc_state_e             state;
    vc_state_e             state_next;
    port_e                 route;
    port_e                 route_next;
    logic [FLIT_WIDTH-1:0] top;
    logic                  full;
    logic                  empty;
    logic                  write;
    logic                  push;
    logic                  pop;
    logic                  drop_entry;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign write           = i_valid && (i_vc == VC_WIDTH'(v));
    assign push            = write && (!full || pop);
    assign overflow_vec[v] = write && full && !pop;

    tnoc_vc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FLIT_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .data  (i_flit),
      .pop   (pop),
      .top   (top),
      .full  (full),
      .empty (empty)
    );

    always_comb begin
      state_next = state;
      route_next = route;
      pop        = 1'b0;
      drop_entry = 1'b0;
      case (state)
        VC_IDLE: begin
          if (!empty) begin
            if (top[HEAD_BIT]) begin
              route_next = xy_route(top);
              if (AVAILABLE_PORTS[route_next]) begin
                state_next = VC_REQUEST;
              end else begin
                state_next = VC_DROP;
                drop_entry = 1'b1;
              end
            end else begin
              pop = 1'b1;
            end
          end
        end
        VC_REQUEST: begin
          if (i_grant[v]) state_next = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (!empty && i_ready[v]) begin
            pop = 1'b1;
            if (top[TAIL_BIT]) state_next = VC_IDLE;
          end
        end
        VC_DROP: begin
          if (!empty) begin
            pop = 1'b1;
            if (top[TAIL_BIT]) state_next = VC_IDLE;
          end
        end
        default: state_next = VC_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= VC_IDLE;
        route <= PORT_L;
      end else begin
        state <= state_next;
        route <= route_next;
      end
    end

    assign pop_vec[v]  = pop;
    assign drop_vec[v] = drop_entry;
    assign o_request[v*5 +: 5] = (state == VC_REQUEST || state == VC_ACTIVE) ?
                                 port_onehot(route) : 5'b00000;
    assign o_valid[v] = (state == VC_ACTIVE) && !empty;
    assign o_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = top;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_credit      <= '0;
      o_overflow    <= 1'b0;
      o_route_error <= 1'b0;
    end else begin
      o_credit      <= pop_vec;
      o_overflow    <= o_overflow | (|overflow_vec);
      o_route_error <= |drop_vec;
    end
  end

endmodule

// File: tb/tb_tnoc_vc_input_unit.sv
// Randomized bench for tnoc_vc_input_unit: packet-level scoreboard per VC,
// credit accounting as an upstream sender would keep it, plus directed cases.
module tb_tnoc_vc_input_unit;

  localparam int         CH    = 2;
  localparam int         DEPTH = 4;
  localparam int         FW    = 64;
  localparam int         MX    = 1;
  localparam int         MY    = 1;
  localparam logic [4:0] AVAIL = 5'b01111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_vc = 1'b0;
  logic [FW-1:0] i_flit = '0;
  logic [CH-1:0] i_grant = '0;
  logic [CH-1:0] i_ready = '0;
  logic [CH-1:0] o_credit;
  logic [CH*5-1:0] o_request;
  logic [CH-1:0] o_valid;
  logic [CH*FW-1:0] o_flit;
  logic          o_overflow;
  logic          o_route_error;

  tnoc_vc_input_unit #(
    .CHANNELS(CH), .DEPTH(DEPTH), .FLIT_WIDTH(FW), .XY_WIDTH(4),
    .X(MX), .Y(MY), .AVAILABLE_PORTS(AVAIL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_vc(i_vc), .i_flit(i_flit),
    .o_credit(o_credit), .o_request(o_request), .i_grant(i_grant),
    .o_valid(o_valid), .o_flit(o_flit), .i_ready(i_ready),
    .o_overflow(o_overflow), .o_route_error(o_route_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [63:0] exp_q [CH][$];
  int          exp_rt [CH][$];
  int          sent [CH];
  int          cred [CH];
  bit          in_pkt [CH];
  bit          pkt_fwd [CH];
  int          pkt_rt [CH];
  int          exp_err = 0;
  int          err_seen = 0;
  int          rem [CH];
  int          gdx [CH];
  int          gdy [CH];

  function automatic int route_of(input int dx, input int dy);
    if (dx > MX) return 0;
    if (dx < MX) return 1;
    if (dy > MY) return 2;
    if (dy < MY) return 3;
    return 4;
  endfunction

  function automatic logic [63:0] mk_flit(input bit h, input bit t, input int dx, input int dy);
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[63] = h;
    f[62] = t;
    f[3:0] = 4'(dx);
    f[7:4] = 4'(dy);
    return f;
  endfunction

  task automatic model_push(input int v, input logic [63:0] f);
    int r;
    sent[v]++;
    if (f[63]) begin
      r = route_of(int'(f[3:0]), int'(f[7:4]));
      in_pkt[v]  = !f[62];
      pkt_fwd[v] = AVAIL[r];
      pkt_rt[v]  = r;
      if (!pkt_fwd[v]) exp_err++;
    end else if (!in_pkt[v]) begin
      return;
    end else if (f[62]) begin
      in_pkt[v] = 1'b0;
    end
    if (pkt_fwd[v]) begin
      exp_q[v].push_back(f);
      exp_rt[v].push_back(pkt_rt[v]);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < CH; v++) begin
      exp_q[v].delete();
      exp_rt[v].delete();
      sent[v] = 0; cred[v] = 0; in_pkt[v] = 0; pkt_fwd[v] = 0; rem[v] = 0;
    end
    exp_err = 0;
    err_seen = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_route_error) err_seen++;
      for (int v = 0; v < CH; v++) begin
        if (o_credit[v]) cred[v]++;
        if (o_valid[v] && i_ready[v]) begin
          if (exp_q[v].size() == 0) begin
            chk("pending_flits", 64'(exp_q[v].size()), 64'(1));
          end else begin
            logic [63:0] f;
            int r;
            f = exp_q[v].pop_front();
            r = exp_rt[v].pop_front();
            chk("flit", o_flit[v*FW +: FW], f);
            chk("request", 64'(o_request[v*5 +: 5]), 64'(5'(1 << r)));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input int v, input logic [63:0] f, input bit track);
    i_valid = 1'b1;
    i_vc    = 1'(v);
    i_flit  = f;
    if (track) model_push(v, f);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic next_flit(input int v, output logic [63:0] f);
    int len;
    if (rem[v] == 0) begin
      if ($urandom_range(0, 15) == 0) begin
        f = mk_flit(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
        return;
      end
      len = $urandom_range(1, 4);
      gdx[v] = $urandom_range(0, 3);
      gdy[v] = $urandom_range(0, 3);
      // only VC0 may hit the unavailable local port, so drops never coincide
      if (v == 1 && gdx[v] == MX && gdy[v] == MY) gdy[v] = 2;
      f = mk_flit(1'b1, len == 1, gdx[v], gdy[v]);
      rem[v] = len - 1;
    end else begin
      rem[v]--;
      f = mk_flit(1'b0, rem[v] == 0, $urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    bit done;
    n = 0;
    i_valid = 1'b0;
    i_ready = '1;
    i_grant = '1;
    done = 1'b0;
    while (n < 200 && !done) begin
      tick();
      n++;
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
             (cred[0] == sent[0]) && (cred[1] == sent[1]);
    end
    chk({tag, "_drained"}, 64'(done), 64'(1));
    for (int v = 0; v < CH; v++) chk({tag, "_credits"}, 64'(cred[v]), 64'(sent[v]));
    chk({tag, "_route_errors"}, 64'(err_seen), 64'(exp_err));
    i_ready = '0;
    i_grant = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    int v;
    model_clear();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", 64'(o_credit), 64'(0));
    chk("rst_request", 64'(o_request), 64'(0));
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_overflow", 64'(o_overflow), 64'(0));
    chk("rst_route_error", 64'(o_route_error), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 3-flit packet to (3,1) on VC0, grant two cycles after the request
    send_flit(0, mk_flit(1, 0, 3, 1), 1);
    send_flit(0, mk_flit(0, 0, 5, 5), 1);
    send_flit(0, mk_flit(0, 1, 6, 6), 1);
    chk("t1_request", 64'(o_request[4:0]), 64'(5'b00001));
    chk("t1_no_valid", 64'(o_valid[0]), 64'(0));
    tick();
    chk("t1_request_held", 64'(o_request[4:0]), 64'(5'b00001));
    i_grant = 2'b01;
    i_ready = 2'b01;
    tick();
    i_grant = 2'b00;
    chk("t1_valid_after_grant", 64'(o_valid[0]), 64'(1));
    chk("t1_no_credit_yet", 64'(o_credit[0]), 64'(0));
    tick();
    chk("t1_credit_pulse", 64'(o_credit[0]), 64'(1));
    tick();
    chk("t1_request_before_tail", 64'(o_request[4:0]), 64'(5'b00001));
    tick();
    chk("t1_request_after_tail", 64'(o_request[4:0]), 64'(0));
    chk("t1_valid_after_tail", 64'(o_valid[0]), 64'(0));
    drain("t1");

    // packet to the unavailable local port is dropped
    send_flit(0, mk_flit(1, 0, MX, MY), 1);
    send_flit(0, mk_flit(0, 0, 0, 0), 1);
    send_flit(0, mk_flit(0, 1, 0, 0), 1);
    drain("drop");

    // five single-flit packets into a 4-deep VC1 with nothing draining
    for (int i = 0; i < 4; i++) send_flit(1, mk_flit(1, 1, 3, 3), 1);
    chk("ovf_not_yet", 64'(o_overflow), 64'(0));
    send_flit(1, mk_flit(1, 1, 3, 3), 0);
    chk("ovf_set", 64'(o_overflow), 64'(1));
    drain("ovf");

    // single-flit packet then back-to-back packets with free-flowing grant/ready
    i_grant = '1;
    i_ready = '1;
    send_flit(1, mk_flit(1, 1, 0, 2), 1);
    send_flit(1, mk_flit(1, 0, 1, 3), 1);
    send_flit(1, mk_flit(0, 1, 9, 9), 1);
    send_flit(1, mk_flit(1, 0, 2, 0), 1);
    send_flit(1, mk_flit(0, 1, 9, 9), 1);
    drain("b2b");

    // randomized interleaving across both VCs, sender obeys credits
    for (int c = 0; c < 3000; c++) begin
      i_ready = 2'($urandom);
      i_grant = 2'($urandom);
      v = $urandom_range(0, 1);
      if ((sent[v] - cred[v]) < DEPTH && $urandom_range(0, 3) != 0) begin
        next_flit(v, f);
        i_valid = 1'b1;
        i_vc    = 1'(v);
        i_flit  = f;
        model_push(v, f);
      end else begin
        i_valid = 1'b0;
      end
      tick();
    end
    i_valid = 1'b0;
    // close any open packets so both VCs can finish
    for (int w = 0; w < CH; w++) begin
      while (rem[w] != 0) begin
        while ((sent[w] - cred[w]) >= DEPTH) begin
          i_ready = '1; i_grant = '1;
          tick();
        end
        next_flit(w, f);
        send_flit(w, f, 1);
      end
    end
    drain("random");
    chk("ovf_sticky", 64'(o_overflow), 64'(1));

    // reset in the middle of an active packet
    i_grant = 2'b01;
    i_ready = 2'b00;
    send_flit(0, mk_flit(1, 0, 3, 0), 1);
    send_flit(0, mk_flit(0, 0, 4, 4), 1);
    tick();
    chk("mid_valid_before_reset", 64'(o_valid[0]), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_request", 64'(o_request), 64'(0));
    chk("mid_rst_valid", 64'(o_valid), 64'(0));
    chk("mid_rst_credit", 64'(o_credit), 64'(0));
    chk("mid_rst_overflow", 64'(o_overflow), 64'(0));
    chk("mid_rst_route_error", 64'(o_route_error), 64'(0));
    model_clear();
    i_grant = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // fresh packet after reset on VC1 to (1,0) -> YM
    i_grant = '1;
    i_ready = '1;
    send_flit(1, mk_flit(1, 0, 1, 0), 1);
    send_flit(1, mk_flit(0, 1, 7, 7), 1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tnoc_vc_input_unit.md
# tnoc_vc_input_unit

Router input port for the credit-based NoC. It buffers incoming flits in per-virtual-channel FIFOs of configurable depth and computes an XY route from each head flit. It holds one output-port request per VC for the full packet, drops packets routed to unavailable ports, and returns one credit per flit drained. It sits between an upstream link and the router switch allocator, replacing the valid/ready input block with credit flow control.

## Interface
- CHANNELS, 2: number of virtual channels, 1..8.
- DEPTH, 4: flits per VC FIFO, power of two, ≥2.
- FLIT_WIDTH, 64: flit width; bit FLIT_WIDTH-1 = head, bit FLIT_WIDTH-2 = tail.
- XY_WIDTH, 4: width of each destination coordinate; dest_x = flit[XY_WIDTH-1:0], dest_y = flit[2*XY_WIDTH-1:XY_WIDTH].
- X, 0 / Y, 0: this router's coordinates.
- AVAILABLE_PORTS, 5'b11111: bit order XP, XM, YP, YM, L.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  flit present on link.
- i_vc  in  $clog2(CHANNELS) (min 1)  VC index of incoming flit.
- i_flit  in  FLIT_WIDTH  incoming flit.
- o_credit  out  CHANNELS  one-cycle pulse per flit freed, per VC.
- o_request  out  CHANNELS*5  per-VC one-hot output-port request, VC v at [5v+4:5v].
- i_grant  in  CHANNELS  per-VC grant from switch allocator.
- o_valid  out  CHANNELS  flit available for switch, per VC.
- o_flit  out  CHANNELS*FLIT_WIDTH  head-of-FIFO flit, per VC.
- i_ready  in  CHANNELS  switch accepts o_flit of that VC this cycle.
- o_overflow  out  1  sticky: write into full FIFO seen.
- o_route_error  out  1  one-cycle pulse when a packet is dropped.

## Operation
- Write: i_valid pushes i_flit into FIFO[i_vc]. If that FIFO is full, the flit is discarded, the FIFO is unchanged, and o_overflow sets; it clears only on reset.
- Per-VC FSM, states IDLE, REQUEST, ACTIVE, DROP:
  - IDLE: FIFO non-empty and top is head → compute route, register it, go to REQUEST if the port is available, else DROP. A non-head flit on top in IDLE is popped and discarded, with a credit returned.
  - REQUEST: o_request holds the one-hot route. i_grant → ACTIVE.
  - ACTIVE: o_request still held (packet lock); o_valid = FIFO non-empty. Pop on o_valid & i_ready. Popping a tail → IDLE, and o_request drops the following cycle.
  - DROP: pop one flit per cycle while non-empty, no o_valid; o_route_error pulses on the entry cycle; tail popped → IDLE.
- Route, XY order: dest_x>X → XP; dest_x<X → XM; else dest_y>Y → YP; dest_y<Y → YM; else L. Comparison is unsigned over XY_WIDTH bits.
- A flit with head and tail both set is a single-flit packet: one ACTIVE pop, then back to IDLE.
- Every pop, whether forwarded or dropped, generates exactly one o_credit pulse for that VC.
- VCs are independent. Simultaneous push and pop on one VC keeps the count unchanged and is legal even when the FIFO is full, because the pop frees the slot first.

## Timing
- Reset values: all FSMs IDLE, FIFOs empty; o_credit, o_request, o_valid, o_overflow, o_route_error all 0; o_flit don't-care.
- Push at cycle t → flit visible at FIFO top at t+1.
- Head at top in IDLE at t → o_request asserted at t+1.
- i_grant at t → o_valid can assert at t+1. A grant is ignored outside REQUEST.
- Pop at t → o_credit pulse at t+1, registered.
- Peak throughput is one flit per cycle per VC.
- Reset mid-packet clears all state immediately. Upstream must also reset its credit counters to DEPTH.

## Structure
- tnoc_pkg gains the port index enum (XP=0, XM, YP, YM, L), head/tail bit position constants, and a route-to-one-hot function.
- Sub-module tnoc_vc_fifo: single-VC FIFO with push, pop, full, empty, and top data. It is instantiated CHANNELS times in a generate loop; the FSM and route logic live in the parent.

## Test plan
- X=1,Y=1, VC0 3-flit packet dest (3,1), grant after 2 cycles → o_request[4:0]=00001 (XP); 3 flits out in order; 3 o_credit[0] pulses; request drops after the tail.
- AVAILABLE_PORTS=5'b01111, packet dest (1,1) → route L unavailable → o_route_error one pulse, no o_valid, credits for all flits returned.
- CHANNELS=2, VC0 to YM and VC1 to L interleaved per flit, i_ready random → both packets intact and independent, credit count per VC equals flits sent.
- DEPTH=4, 5 flits to VC1 with i_ready=0 → 5th dropped, o_overflow=1, FIFO holds first 4.
- Single-flit packet and back-to-back packets on one VC, i_ready=1 → head-to-IDLE-to-REQUEST with no lost flits.
- rst_n asserted mid-packet → all outputs 0 the same cycle; a new packet after reset routes correctly.
